// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM with redirect and halt
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);
  typedef enum logic [1:0] {REQ, WAIT, VALID, HALTED} state_t;
  state_t      state;
  logic [15:0] fetch_pc;
  logic        hs;
  // Read strobe is suppressed whenever this cycle's address is about to change or fetch is stopping
  always_comb begin
    mem_addr = fetch_pc;
    mem_en   = (state == REQ) & ~halt & ~redirect;
    hs       = instr_valid & instr_ready;
  end
  // Fetch sequencing; redirect always wins the next fetch address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      fetch_pc    <= RESET_PC;
      instr       <= 16'h0000;
      pc          <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      if (redirect) fetch_pc <= redirect_pc;
      case (state)
        REQ: state <= redirect ? REQ : halt ? HALTED : WAIT;
        WAIT: begin
          if (redirect) state <= REQ;
          else begin
            instr       <= mem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (hs || redirect) begin
            instr_valid <= 1'b0;
            state       <= (hs && halt) ? HALTED : REQ;
            if (hs && !redirect) fetch_pc <= pc + 16'd1;
          end
        end
        HALTED: if (!halt) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for the instruction fetch unit
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a == 16'd0 ? 16'h1111 : a == 16'd1 ? 16'h2222 : a == 16'd2 ? 16'h3333 : a ^ 16'hC3A5;
  endfunction

  // Instruction memory: one-cycle read latency
  always @(posedge clk) if (mem_en) mem_rdata <= data_of(mem_addr);

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted instruction
  always @(negedge clk)
    if (reset && instr_valid && instr_ready) begin
      got_q.push_back({pc, instr});
      got_cyc.push_back(cyc);
    end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (got_q.size() >= n) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (instr_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    halt = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (instr_valid !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_regs got valid=%b pc=%h instr=%h expected 0 0000 0000", instr_valid, pc, instr);
    end
    reset = 1'b1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_first_fetch got en=%b addr=%h expected 1 0000", mem_en, mem_addr);
    end
  endtask

  task automatic test_sequence();
    bit ok;
    logic [31:0] e, g;
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0001, 16'h2222});
    exp_q.push_back({16'h0002, 16'h3333});
    wait_got(3, ok);
    halt = 1'b1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL seq_timeout got %0d expected 3", got_q.size());
    end else begin
      checks++;
      if (got_cyc[1] - got_cyc[0] !== 3 || got_cyc[2] - got_cyc[1] !== 3) begin
        failures++;
        $display("FAIL seq_spacing got %0d,%0d expected 3,3", got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL seq_item got %h expected %h", g, e);
      end
    end
    tick();
    tick();
    checks++;
    if (mem_en !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_halted got en=%b valid=%b expected 0 0", mem_en, instr_valid);
    end
  endtask

  task automatic test_stall_halt();
    bit ok;
    logic [31:0] e, g;
    instr_ready = 1'b0;
    halt = 1'b0;
    tick();
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 16'h0003 || instr !== data_of(16'h0003)) begin
      failures++;
      $display("FAIL stall_first got valid=%b pc=%h instr=%h expected 1 0003 %h", instr_valid, pc, instr, data_of(16'h0003));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc !== 16'h0003 || instr !== data_of(16'h0003) || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got valid=%b pc=%h instr=%h en=%b expected 1 0003 %h 0", instr_valid, pc, instr, mem_en, data_of(16'h0003));
      end
    end
    halt = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || pc !== 16'h0003) begin
      failures++;
      $display("FAIL halt_keeps_valid got valid=%b pc=%h expected 1 0003", instr_valid, pc);
    end
    exp_q.push_back({16'h0003, data_of(16'h0003)});
    instr_ready = 1'b1;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL halt_accept got %h expected %h", g, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_en !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_idle got en=%b valid=%b expected 0 0", mem_en, instr_valid);
      end
      tick();
    end
    halt = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0004) begin
      failures++;
      $display("FAIL halt_resume got en=%b addr=%h expected 1 0004", mem_en, mem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [31:0] e, g;
    do_reset();
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0040, data_of(16'h0040)});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_en && mem_addr == 16'h0001) ok = 1'b1;
      else tick();
    end
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    checks++;
    if (!ok || instr_valid !== 1'b0 || pc !== 16'h0000 || instr !== 16'h1111) begin
      failures++;
      $display("FAIL redirect_wait_discard got valid=%b pc=%h instr=%h expected 0 0000 1111", instr_valid, pc, instr);
    end
    wait_got(2, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL redirect_wait_item got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] e, g;
    do_reset();
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0005;
    tick();
    redirect = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 16'h0005) begin
      failures++;
      $display("FAIL branch_setup got valid=%b pc=%h expected 1 0005", instr_valid, pc);
    end
    exp_q.push_back({16'h0005, data_of(16'h0005)});
    exp_q.push_back({16'h0010, data_of(16'h0010)});
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    wait_got(2, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL branch_hs_item got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_wrap_reset();
    bit ok;
    logic [31:0] e, g;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    exp_q.push_back({16'hFFFF, data_of(16'hFFFF)});
    exp_q.push_back({16'h0000, 16'h1111});
    wait_got(2, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL wrap_item got %h expected %h", g, e);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (mem_en) ok = 1'b1;
      else tick();
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000 || mem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_wait got valid=%b pc=%h instr=%h addr=%h expected 0 0000 0000 0000", instr_valid, pc, instr, mem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold_valid got %b expected 0", instr_valid);
      end
    end
    got_q.delete();
    got_cyc.delete();
    reset = 1'b1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_refetch got en=%b addr=%h expected 1 0000", mem_en, mem_addr);
    end
    exp_q.push_back({16'h0000, 16'h1111});
    wait_got(1, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_first_item got %h expected %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall_halt();
    test_redirect_wait();
    test_back_to_back();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
